// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
//   Shared constants, the controller state type and a helper for the pooled
//   map size. Imported by the pooling interface, the address generator and
//   the controller.
//   DATA_W  : default pixel width (signed fixed point)
//   ACC_W   : accumulator width, two guard bits so four pixels never overflow
//   pool_state_e : IDLE, four fetch states, accumulate, write, done
//   out_w() : output map width for a given input width (floor of half)
// ---------------------------------------------------------------------------
package pool_pkg;

   localparam int DATA_W = 16;
   localparam int ACC_W  = DATA_W + 2;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      F0   = 3'd1,
      F1   = 3'd2,
      F2   = 3'd3,
      F3   = 3'd4,
      ACC  = 3'd5,
      WR   = 3'd6,
      DONE = 3'd7
   } pool_state_e;

   function automatic int out_w(input int img_w);
      return img_w / 2;
   endfunction

endpackage

// File: rtl/pool_if.sv
// ---------------------------------------------------------------------------
// pool_if
//   Bundles the scheduler handshake and the two buffer ports of the pooling
//   controller.
//   start              : scheduler request (controller input)
//   rd_en/rd_addr      : input-buffer read strobe and address
//   rd_data            : input pixel, one cycle after rd_en
//   wr_en/wr_addr/wr_data : output-buffer write port
//   busy/done          : pass status
//   master modport = controller side, slave modport = scheduler/buffer side.
// ---------------------------------------------------------------------------
interface pool_if
   import pool_pkg::*;
#(
   parameter int DATA_W = pool_pkg::DATA_W,
   parameter int ADDR_W = 10
);

   logic              start;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              done;

   modport master (
      input  start, rd_data,
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
   );

   modport slave (
      output start, rd_data,
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
   );

endinterface

// File: rtl/pool_addr_gen.sv
// ---------------------------------------------------------------------------
// pool_addr_gen
//   Owns the output row/column counters of a pooling pass and derives the
//   input read address for the selected window tap and the output address.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the counters (pass start)
//   adv        : step to the next window in row-major order
//   sel        : window tap 0..3 = (0,0) (0,1) (1,0) (1,1)
//   rd_addr    : 2*orow*IMG_W + 2*ocol + tap offset
//   wr_addr    : orow*OUT_W + ocol
//   last       : current window is the final one of the pass
// ---------------------------------------------------------------------------
module pool_addr_gen
   import pool_pkg::*;
#(
   parameter int IMG_W  = 28,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              adv,
   input  logic [1:0]        sel,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              last
);

   localparam int                OUT_W    = out_w(IMG_W);
   localparam logic [ADDR_W-1:0] IMG_A    = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] OUT_A    = ADDR_W'(OUT_W);
   localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_W - 1);

   logic [ADDR_W-1:0] orow_reg;
   logic [ADDR_W-1:0] ocol_reg;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] offset_tab [4];

   // Tap offsets: bit 1 selects the lower input row, bit 0 the right column.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_off
         assign offset_tab[gi] = ADDR_W'((gi / 2) * IMG_W + (gi % 2));
      end
   endgenerate

   assign base    = ((orow_reg * IMG_A) << 1) + (ocol_reg << 1);
   assign rd_addr = base + offset_tab[sel];
   assign wr_addr = orow_reg * OUT_A + ocol_reg;
   assign last    = (orow_reg == OUT_LAST) && (ocol_reg == OUT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         orow_reg <= '0;
         ocol_reg <= '0;
      end else if (clr) begin
         orow_reg <= '0;
         ocol_reg <= '0;
      end else if (adv) begin
         if (ocol_reg == OUT_LAST) begin
            ocol_reg <= '0;
            // After the final window park at zero so the next pass starts clean.
            orow_reg <= last ? '0 : orow_reg + 1'b1;
         end else begin
            ocol_reg <= ocol_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pool_controller.sv
// ---------------------------------------------------------------------------
// pool_controller
//   Time-shared 2x2 average pooling over a square IMG_W x IMG_W map. Each
//   window takes six cycles: four reads, a final accumulate, one write.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pool_if master (start, read port, write port, busy, done)
// ---------------------------------------------------------------------------
module pool_controller
   import pool_pkg::*;
#(
   parameter int IMG_W  = 28,
   parameter int DATA_W = pool_pkg::DATA_W,
   parameter int ADDR_W = 10
) (
   input  logic   clk,
   input  logic   rst_n,
   pool_if.master bus
);

   localparam int ACC_W = DATA_W + 2;

   localparam logic [2:0] S_IDLE = IDLE;
   localparam logic [2:0] S_F0   = F0;
   localparam logic [2:0] S_F1   = F1;
   localparam logic [2:0] S_F2   = F2;
   localparam logic [2:0] S_F3   = F3;
   localparam logic [2:0] S_ACC  = ACC;
   localparam logic [2:0] S_WR   = WR;
   localparam logic [2:0] S_DONE = DONE;

   logic [2:0]               state_reg;
   logic [2:0]               state_next;
   logic signed [ACC_W-1:0]  acc_reg;
   logic signed [ACC_W-1:0]  pix_ext;
   logic signed [ACC_W-1:0]  acc_sum;
   logic [DATA_W-1:0]        wr_data_reg;
   logic [ADDR_W-1:0]        wr_addr_reg;
   logic [ADDR_W-1:0]        rd_addr_hold_reg;
   logic [ADDR_W-1:0]        gen_rd_addr;
   logic [ADDR_W-1:0]        gen_wr_addr;
   logic                     gen_last;
   logic                     fetch;
   logic [1:0]               fetch_sel;

   pool_addr_gen #(
      .IMG_W  (IMG_W),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     ((state_reg == S_IDLE) && bus.start),
      .adv     (state_reg == S_WR),
      .sel     (fetch_sel),
      .rd_addr (gen_rd_addr),
      .wr_addr (gen_wr_addr),
      .last    (gen_last)
   );

   assign pix_ext = {{2{bus.rd_data[DATA_W-1]}}, bus.rd_data};
   assign acc_sum = acc_reg + pix_ext;

   always_comb begin
      fetch     = 1'b0;
      fetch_sel = 2'd0;
      case (state_reg)
         S_F0:    begin fetch = 1'b1; fetch_sel = 2'd0; end
         S_F1:    begin fetch = 1'b1; fetch_sel = 2'd1; end
         S_F2:    begin fetch = 1'b1; fetch_sel = 2'd2; end
         S_F3:    begin fetch = 1'b1; fetch_sel = 2'd3; end
         default: ;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (bus.start) state_next = S_F0;
         S_F0:    state_next = S_F1;
         S_F1:    state_next = S_F2;
         S_F2:    state_next = S_F3;
         S_F3:    state_next = S_ACC;
         S_ACC:   state_next = S_WR;
         S_WR:    state_next = gen_last ? S_DONE : S_F0;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // rd_data lags the fetch by one cycle, so the first pixel of a window
   // lands in F1 and the fourth is folded in during ACC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= S_IDLE;
         acc_reg          <= '0;
         wr_data_reg      <= '0;
         wr_addr_reg      <= '0;
         rd_addr_hold_reg <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            S_F1:       acc_reg <= pix_ext;
            S_F2, S_F3: acc_reg <= acc_sum;
            S_ACC: begin
               acc_reg     <= acc_sum;
               wr_data_reg <= acc_sum[ACC_W-1:2];
               wr_addr_reg <= gen_wr_addr;
            end
            default: ;
         endcase
         if (fetch) begin
            rd_addr_hold_reg <= gen_rd_addr;
         end
      end
   end

   // Outside the fetch states the read address keeps the last value issued.
   assign bus.rd_en   = fetch;
   assign bus.rd_addr = fetch ? gen_rd_addr : rd_addr_hold_reg;
   assign bus.wr_en   = (state_reg == S_WR);
   assign bus.wr_addr = wr_addr_reg;
   assign bus.wr_data = wr_data_reg;
   assign bus.busy    = (state_reg != S_IDLE) && (state_reg != S_DONE);
   assign bus.done    = (state_reg == S_DONE);

endmodule

// File: tb/tb_pool_controller.sv
module tb_pool_controller;

   localparam int AW = 10;
   localparam int DW = 16;

   typedef struct { int addr; int data; } wr_t;
   typedef wr_t wrq_t[$];

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pool_if #(.DATA_W(DW), .ADDR_W(AW)) bus4 ();
   pool_if #(.DATA_W(DW), .ADDR_W(AW)) bus5 ();

   pool_controller #(.IMG_W(4), .DATA_W(DW), .ADDR_W(AW)) u4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4.master));
   pool_controller #(.IMG_W(5), .DATA_W(DW), .ADDR_W(AW)) u5 (
      .clk(clk), .rst_n(rst_n), .bus(bus5.master));

   logic [DW-1:0] mem4 [1024];
   logic [DW-1:0] mem5 [1024];

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   wrq_t wq4, wq5;
   int   done4[$];
   int   done5[$];
   int   rd5[$];
   int   overlap = 0;
   wr_t  e4, e5;

   // Input buffers: one-cycle read latency.
   always @(posedge clk) begin
      if (!rst_n) begin
         bus4.rd_data <= '0;
         bus5.rd_data <= '0;
      end else begin
         if (bus4.rd_en) bus4.rd_data <= mem4[bus4.rd_addr];
         if (bus5.rd_en) bus5.rd_data <= mem5[bus5.rd_addr];
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Observers sample on the falling edge.
   always @(negedge clk) begin
      if (bus4.wr_en) begin
         e4.addr = int'(bus4.wr_addr);
         e4.data = int'($signed(bus4.wr_data));
         wq4.push_back(e4);
      end
      if (bus5.wr_en) begin
         e5.addr = int'(bus5.wr_addr);
         e5.data = int'($signed(bus5.wr_data));
         wq5.push_back(e5);
      end
      if (bus4.done) done4.push_back(cyc);
      if (bus5.done) done5.push_back(cyc);
      if (bus5.rd_en) rd5.push_back(int'(bus5.rd_addr));
      if ((bus4.rd_en && bus4.wr_en) || (bus5.rd_en && bus5.wr_en)) overlap++;
   end

   // Reference: average of each non-overlapping 2x2 window, floored.
   function automatic int px(input int img, input int a);
      return (img == 4) ? int'($signed(mem4[a])) : int'($signed(mem5[a]));
   endfunction

   function automatic wrq_t model(input int img);
      wrq_t q;
      wr_t  e;
      int   n, b, s;
      n = img / 2;
      for (int r = 0; r < n; r++) begin
         for (int c = 0; c < n; c++) begin
            b = 2 * r * img + 2 * c;
            s = px(img, b) + px(img, b + 1) + px(img, b + img) + px(img, b + img + 1);
            e.addr = r * n + c;
            e.data = s >>> 2;
            q.push_back(e);
         end
      end
      return q;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      wq4.delete(); wq5.delete(); done4.delete(); done5.delete(); rd5.delete();
   endtask

   // acc = index of the cycle in which start is sampled in IDLE.
   task automatic pulse4(output int acc);
      bus4.start = 1'b1; acc = cyc; tick(); bus4.start = 1'b0;
   endtask

   task automatic pulse5(output int acc);
      bus5.start = 1'b1; acc = cyc; tick(); bus5.start = 1'b0;
   endtask

   task automatic wait_done4(input int n);
      for (int k = 0; k < 400 && done4.size() < n; k++) tick();
   endtask

   task automatic wait_done5(input int n);
      for (int k = 0; k < 400 && done5.size() < n; k++) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bus4.start = 1'b0; bus5.start = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({bus4.rd_en, bus4.wr_en, bus4.busy, bus4.done, bus4.rd_addr, bus4.wr_addr, bus4.wr_data} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got busy=%b rd_en=%b rd_addr=%0d wr_data=%h, want all 0",
                            bus4.busy, bus4.rd_en, bus4.rd_addr, bus4.wr_data);
      end
      rst_n = 1'b1;
      repeat (3) tick();
      n_checks++;
      if ({bus4.busy, bus4.done, bus4.wr_en, bus5.busy, bus5.wr_en} !== 5'b0) begin
         n_fail++; $display("FAIL idle_after_reset: got busy4=%b busy5=%b wr4=%b, want 0", bus4.busy, bus5.busy, bus4.wr_en);
      end
      $display("test_reset done");
   endtask

   task automatic test_ramp4();
      int acc;
      int want [4] = '{2, 4, 10, 12};
      clear_logs();
      for (int i = 0; i < 16; i++) mem4[i] = DW'(i);
      pulse4(acc);
      n_checks++;
      if (bus4.busy !== 1'b1) begin
         n_fail++; $display("FAIL ramp4_busy: got %b, want 1", bus4.busy);
      end
      wait_done4(1);
      repeat (3) tick();
      n_checks++;
      if (wq4.size() != 4) begin
         n_fail++; $display("FAIL ramp4_count: got %0d writes, want 4", wq4.size());
      end
      for (int i = 0; i < 4 && i < wq4.size(); i++) begin
         n_checks++;
         if (wq4[i].addr !== i || wq4[i].data !== want[i]) begin
            n_fail++; $display("FAIL ramp4_wr[%0d]: got addr %0d data %0d, want addr %0d data %0d",
                               i, wq4[i].addr, wq4[i].data, i, want[i]);
         end
      end
      n_checks++;
      if (done4.size() != 1 || done4[0] - acc != 25) begin
         n_fail++; $display("FAIL ramp4_done_latency: got %0d pulses, latency %0d, want 1 pulse, 25",
                            done4.size(), (done4.size() > 0) ? done4[0] - acc : -1);
      end
      $display("test_ramp4 writes=%0d", wq4.size());
   endtask

   task automatic test_random4();
      int acc;
      wrq_t exp;
      for (int p = 0; p < 3; p++) begin
         clear_logs();
         for (int i = 0; i < 16; i++) mem4[i] = DW'($urandom_range(0, 65535));
         exp = model(4);
         pulse4(acc);
         wait_done4(1);
         repeat (2) tick();
         n_checks++;
         if (wq4.size() != exp.size()) begin
            n_fail++; $display("FAIL random4_count[%0d]: got %0d, want %0d", p, wq4.size(), exp.size());
         end
         for (int i = 0; i < exp.size() && i < wq4.size(); i++) begin
            n_checks++;
            if (wq4[i].addr !== exp[i].addr || wq4[i].data !== exp[i].data) begin
               n_fail++; $display("FAIL random4_wr[%0d.%0d]: got addr %0d data %0d, want addr %0d data %0d",
                                  p, i, wq4[i].addr, wq4[i].data, exp[i].addr, exp[i].data);
            end
         end
         $display("test_random4 pass %0d writes=%0d", p, wq4.size());
      end
   endtask

   task automatic test_extremes();
      int acc;
      clear_logs();
      for (int i = 0; i < 16; i++) mem4[i] = DW'($urandom_range(0, 65535));
      mem4[0] = 16'h7FFF; mem4[1] = 16'h7FFF; mem4[4] = 16'h7FFF; mem4[5] = 16'h7FFF;
      mem4[2] = 16'hFFFF; mem4[3] = 16'hFFFF; mem4[6] = 16'hFFFF; mem4[7] = 16'hFFFE;
      pulse4(acc);
      wait_done4(1);
      repeat (2) tick();
      n_checks++;
      if (wq4.size() < 2 || wq4[0].data !== 32767) begin
         n_fail++; $display("FAIL extreme_max: got %0d, want 32767", (wq4.size() > 0) ? wq4[0].data : 0);
      end
      n_checks++;
      if (wq4.size() < 2 || wq4[1].data !== -2) begin
         n_fail++; $display("FAIL extreme_neg_floor: got %0d, want -2", (wq4.size() > 1) ? wq4[1].data : 0);
      end
      $display("test_extremes writes=%0d", wq4.size());
   endtask

   task automatic test_odd5();
      int acc, bad;
      int want [4] = '{3, 5, 13, 15};
      int first [4] = '{0, 1, 5, 6};
      wrq_t exp;
      clear_logs();
      for (int i = 0; i < 25; i++) mem5[i] = DW'(i);
      pulse5(acc);
      wait_done5(1);
      repeat (2) tick();
      bad = 0;
      foreach (rd5[i]) if (rd5[i] / 5 == 4 || rd5[i] % 5 == 4) bad++;
      n_checks++;
      if (rd5.size() != 16 || bad != 0) begin
         n_fail++; $display("FAIL odd5_reads: got %0d reads, %0d in row/col 4, want 16, 0", rd5.size(), bad);
      end
      for (int i = 0; i < 4 && i < rd5.size(); i++) begin
         n_checks++;
         if (rd5[i] !== first[i]) begin
            n_fail++; $display("FAIL odd5_first_rd[%0d]: got %0d, want %0d", i, rd5[i], first[i]);
         end
      end
      n_checks++;
      if (wq5.size() != 4) begin
         n_fail++; $display("FAIL odd5_count: got %0d, want 4", wq5.size());
      end
      for (int i = 0; i < 4 && i < wq5.size(); i++) begin
         n_checks++;
         if (wq5[i].addr !== i || wq5[i].data !== want[i]) begin
            n_fail++; $display("FAIL odd5_wr[%0d]: got addr %0d data %0d, want addr %0d data %0d",
                               i, wq5[i].addr, wq5[i].data, i, want[i]);
         end
      end
      n_checks++;
      if (done5.size() != 1 || done5[0] - acc != 25) begin
         n_fail++; $display("FAIL odd5_done_latency: got %0d, want 25", (done5.size() > 0) ? done5[0] - acc : -1);
      end
      // Random pass on the odd map.
      clear_logs();
      for (int i = 0; i < 25; i++) mem5[i] = DW'($urandom_range(0, 65535));
      exp = model(5);
      pulse5(acc);
      wait_done5(1);
      repeat (2) tick();
      for (int i = 0; i < exp.size(); i++) begin
         n_checks++;
         if (i >= wq5.size() || wq5[i].addr !== exp[i].addr || wq5[i].data !== exp[i].data) begin
            n_fail++; $display("FAIL odd5_random_wr[%0d]: got addr %0d data %0d, want addr %0d data %0d", i,
                               (i < wq5.size()) ? wq5[i].addr : -1, (i < wq5.size()) ? wq5[i].data : 0,
                               exp[i].addr, exp[i].data);
         end
      end
      $display("test_odd5 reads=%0d writes=%0d", rd5.size(), wq5.size());
   endtask

   task automatic test_restart_ignored();
      int acc;
      wrq_t exp;
      clear_logs();
      for (int i = 0; i < 16; i++) mem4[i] = DW'($urandom_range(0, 65535));
      exp = model(4);
      pulse4(acc);
      while (cyc < acc + 7) tick();
      bus4.start = 1'b1; tick(); bus4.start = 1'b0;
      wait_done4(1);
      repeat (40) tick();
      n_checks++;
      if (wq4.size() != 4 || done4.size() != 1) begin
         n_fail++; $display("FAIL restart_count: got %0d writes %0d dones, want 4, 1", wq4.size(), done4.size());
      end
      for (int i = 0; i < 4 && i < wq4.size(); i++) begin
         n_checks++;
         if (wq4[i].addr !== exp[i].addr || wq4[i].data !== exp[i].data) begin
            n_fail++; $display("FAIL restart_wr[%0d]: got addr %0d data %0d, want addr %0d data %0d",
                               i, wq4[i].addr, wq4[i].data, exp[i].addr, exp[i].data);
         end
      end
      n_checks++;
      if (done4.size() < 1 || done4[0] - acc != 25) begin
         n_fail++; $display("FAIL restart_latency: got %0d, want 25", (done4.size() > 0) ? done4[0] - acc : -1);
      end
      $display("test_restart_ignored writes=%0d", wq4.size());
   endtask

   task automatic test_reset_mid();
      int acc;
      wrq_t exp;
      clear_logs();
      for (int i = 0; i < 16; i++) mem4[i] = DW'($urandom_range(0, 65535));
      exp = model(4);
      pulse4(acc);
      while (cyc < acc + 9) tick();
      // Second window (orow 0, ocol 1) is fetching its lower-left tap now.
      n_checks++;
      if (bus4.rd_en !== 1'b1 || bus4.rd_addr !== 10'd6) begin
         n_fail++; $display("FAIL midpass_rd: got rd_en=%b addr %0d, want 1, 6", bus4.rd_en, bus4.rd_addr);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus4.rd_en, bus4.wr_en, bus4.busy, bus4.done, bus4.rd_addr, bus4.wr_addr, bus4.wr_data} !== '0) begin
         n_fail++; $display("FAIL midpass_reset_outputs: got busy=%b rd_en=%b rd_addr=%0d wr_addr=%0d, want all 0",
                            bus4.busy, bus4.rd_en, bus4.rd_addr, bus4.wr_addr);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (12) tick();
      n_checks++;
      if (wq4.size() != 1 || done4.size() != 0 || bus4.busy !== 1'b0) begin
         n_fail++; $display("FAIL midpass_abandon: got %0d writes %0d dones busy=%b, want 1, 0, 0",
                            wq4.size(), done4.size(), bus4.busy);
      end
      clear_logs();
      pulse4(acc);
      wait_done4(1);
      repeat (2) tick();
      n_checks++;
      if (wq4.size() != 4) begin
         n_fail++; $display("FAIL after_reset_count: got %0d, want 4", wq4.size());
      end
      for (int i = 0; i < 4 && i < wq4.size(); i++) begin
         n_checks++;
         if (wq4[i].addr !== exp[i].addr || wq4[i].data !== exp[i].data) begin
            n_fail++; $display("FAIL after_reset_wr[%0d]: got addr %0d data %0d, want addr %0d data %0d",
                               i, wq4[i].addr, wq4[i].data, exp[i].addr, exp[i].data);
         end
      end
      $display("test_reset_mid writes=%0d", wq4.size());
   endtask

   task automatic test_back_to_back();
      int acc;
      wrq_t exp;
      clear_logs();
      for (int i = 0; i < 16; i++) mem4[i] = DW'($urandom_range(0, 65535));
      exp = model(4);
      bus4.start = 1'b1;
      acc = cyc;
      for (int k = 0; k < 400 && done4.size() < 2; k++) begin
         tick();
         if (done4.size() == 1 && cyc == done4[0] + 1) begin
            n_checks++;
            if (bus4.busy !== 1'b0 || bus4.rd_en !== 1'b0) begin
               n_fail++; $display("FAIL b2b_idle_gap: got busy=%b rd_en=%b, want 0, 0", bus4.busy, bus4.rd_en);
            end
         end
      end
      bus4.start = 1'b0;
      repeat (40) tick();
      n_checks++;
      if (wq4.size() != 8 || done4.size() != 2) begin
         n_fail++; $display("FAIL b2b_count: got %0d writes %0d dones, want 8, 2", wq4.size(), done4.size());
      end
      for (int i = 0; i < 8 && i < wq4.size(); i++) begin
         n_checks++;
         if (wq4[i].addr !== exp[i % 4].addr || wq4[i].data !== exp[i % 4].data) begin
            n_fail++; $display("FAIL b2b_wr[%0d]: got addr %0d data %0d, want addr %0d data %0d",
                               i, wq4[i].addr, wq4[i].data, exp[i % 4].addr, exp[i % 4].data);
         end
      end
      n_checks++;
      if (done4.size() != 2 || done4[0] - acc != 25 || done4[1] - done4[0] != 26) begin
         n_fail++; $display("FAIL b2b_done_timing: got first %0d gap %0d, want 25, 26",
                            (done4.size() > 0) ? done4[0] - acc : -1,
                            (done4.size() > 1) ? done4[1] - done4[0] : -1);
      end
      n_checks++;
      if (overlap != 0) begin
         n_fail++; $display("FAIL rd_wr_overlap: got %0d cycles, want 0", overlap);
      end
      $display("test_back_to_back writes=%0d dones=%0d", wq4.size(), done4.size());
   endtask

   initial begin
      test_reset();
      test_ramp4();
      test_random4();
      test_extremes();
      test_odd5();
      test_restart_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
